// File: rtl/nunchuck_poller.sv
// nunchuck_poller: autonomous poller for a Wii nunchuck behind a generic
// transaction-level I2C master. It initialises the device, then
// periodically issues a conversion write, waits, reads the 6-byte report
// and publishes it atomically on data_out.
//
// Optional feature macro: NUNCHUCK_LEGACY_INIT_EN
//   defined   : single init write 0x40,0x00; bytes stored as ((b^0x17)+0x17)
//   undefined : init writes 0xF0,0x55 then 0xFB,0x00; bytes stored raw
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   en                         polling enable
//   txn_req/rw/addr/len        transaction request and attributes to master
//   txn_wdata0/1               write payload bytes
//   txn_done/txn_nack          completion strobe and failure flag
//   rd_valid/rd_data           received read bytes
//   data_out[0:5]/data_valid   last good report and its update pulse
//   init_done/link_err         device initialised / re-init was forced
//   err_count                  saturating failed-transaction count
module nunchuck_poller #(
    parameter logic [6:0]  DEV_ADDR    = 7'h52,
    parameter int unsigned POLL_CYCLES = 50000,
    parameter int unsigned CONV_WAIT   = 10000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       txn_req,
    output logic       txn_rw,
    output logic [6:0] txn_addr,
    output logic [2:0] txn_len,
    output logic [7:0] txn_wdata0,
    output logic [7:0] txn_wdata1,
    input  logic       txn_done,
    input  logic       txn_nack,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    output logic [7:0] data_out [0:5],
    output logic       data_valid,
    output logic       init_done,
    output logic       link_err,
    output logic [7:0] err_count
);

    localparam int unsigned PCW = $clog2(POLL_CYCLES + 1);
    localparam int unsigned CWW = $clog2(CONV_WAIT + 1);
    localparam int unsigned RTW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_INIT1, S_INIT2, S_POLL_WAIT, S_CONV, S_CONV_WAIT, S_READ, S_PUBLISH
    } state_t;

    state_t           r_state, w_state_n;
    logic             r_req, w_req_n;
    logic             r_gap, w_gap_n;       // issue the current transaction next cycle
    logic [PCW-1:0]   r_poll_cnt, w_poll_cnt_n;
    logic [CWW-1:0]   r_wait_cnt, w_wait_cnt_n;
    logic [RTW-1:0]   r_retry, w_retry_n;
    logic [2:0]       r_nbytes, w_nbytes_n;
    logic [7:0]       r_shadow [0:5];
    logic [7:0]       w_shadow_n [0:5];
    logic [7:0]       r_data [0:5];
    logic [7:0]       w_data_n [0:5];
    logic             r_dv, w_dv_n;
    logic             r_init_done, w_init_done_n;
    logic             r_link_err, w_link_err_n;
    logic [7:0]       r_err, w_err_n;
    logic             r_rw, w_rw_n;
    logic [2:0]       r_len, w_len_n;
    logic [7:0]       r_wd0, w_wd0_n;
    logic [7:0]       r_wd1, w_wd1_n;
    logic             w_done;
    logic             w_cap;
    logic             w_ok;
    logic [2:0]       w_cnt;

    // Byte storage transform applied at capture time.
    function automatic logic [7:0] f_store(input logic [7:0] b);
`ifdef NUNCHUCK_LEGACY_INIT_EN
        return 8'((b ^ 8'h17) + 8'h17);
`else
        return b;
`endif
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_INIT1;
            r_req       <= 1'b0;
            r_gap       <= 1'b1;
            r_poll_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_retry     <= '0;
            r_nbytes    <= '0;
            r_shadow    <= '{default: 8'h00};
            r_data      <= '{default: 8'h00};
            r_dv        <= 1'b0;
            r_init_done <= 1'b0;
            r_link_err  <= 1'b0;
            r_err       <= '0;
            r_rw        <= 1'b0;
            r_len       <= '0;
            r_wd0       <= '0;
            r_wd1       <= '0;
        end else begin
            r_state     <= w_state_n;
            r_req       <= w_req_n;
            r_gap       <= w_gap_n;
            r_poll_cnt  <= w_poll_cnt_n;
            r_wait_cnt  <= w_wait_cnt_n;
            r_retry     <= w_retry_n;
            r_nbytes    <= w_nbytes_n;
            r_shadow    <= w_shadow_n;
            r_data      <= w_data_n;
            r_dv        <= w_dv_n;
            r_init_done <= w_init_done_n;
            r_link_err  <= w_link_err_n;
            r_err       <= w_err_n;
            r_rw        <= w_rw_n;
            r_len       <= w_len_n;
            r_wd0       <= w_wd0_n;
            r_wd1       <= w_wd1_n;
        end
    end

    // Next-state, handshake, retry and capture logic.
    always_comb begin
        w_state_n     = r_state;
        w_req_n       = r_req;
        w_gap_n       = 1'b0;
        w_poll_cnt_n  = r_poll_cnt;
        w_wait_cnt_n  = r_wait_cnt;
        w_retry_n     = r_retry;
        w_nbytes_n    = r_nbytes;
        w_shadow_n    = r_shadow;
        w_data_n      = r_data;
        w_dv_n        = 1'b0;
        w_init_done_n = r_init_done;
        w_link_err_n  = r_link_err;
        w_err_n       = r_err;
        w_rw_n        = r_rw;
        w_len_n       = r_len;
        w_wd0_n       = r_wd0;
        w_wd1_n       = r_wd1;

        w_done = txn_done && r_req;
        w_cap  = rd_valid && r_req && (r_state == S_READ) && (r_nbytes < 3'd6);
        w_cnt  = w_cap ? 3'(r_nbytes + 3'd1) : r_nbytes;
        if (w_cap) begin
            w_shadow_n[r_nbytes] = f_store(rd_data);
            w_nbytes_n           = w_cnt;
        end
        w_ok = !txn_nack && ((r_state != S_READ) || (w_cnt == 3'd6));

        // Poll period runs from CONV entry and saturates so an overrun starts the next poll at once.
        if (r_poll_cnt < PCW'(POLL_CYCLES)) begin
            w_poll_cnt_n = PCW'(r_poll_cnt + PCW'(1));
        end

        if (r_gap) begin
            w_req_n = 1'b1;
        end

        case (r_state)
            S_INIT1, S_INIT2, S_CONV, S_READ: begin
                if (w_done) begin
                    w_req_n    = 1'b0;
                    w_nbytes_n = '0;
                    if (w_ok) begin
                        w_retry_n = '0;
                        case (r_state)
                            S_INIT1: begin
`ifdef NUNCHUCK_LEGACY_INIT_EN
                                w_init_done_n = 1'b1;
                                w_state_n     = S_POLL_WAIT;
                                w_poll_cnt_n  = '0;
`else
                                w_state_n = S_INIT2;
                                w_gap_n   = 1'b1;
`endif
                            end
                            S_INIT2: begin
                                w_init_done_n = 1'b1;
                                w_state_n     = S_POLL_WAIT;
                                w_poll_cnt_n  = '0;
                            end
                            S_CONV: begin
                                w_state_n    = S_CONV_WAIT;
                                w_wait_cnt_n = '0;
                            end
                            default: begin
                                // Publish includes a byte that lands in the same cycle as txn_done.
                                w_state_n = S_PUBLISH;
                                w_data_n  = w_shadow_n;
                                w_dv_n    = 1'b1;
                            end
                        endcase
                    end else begin
                        w_gap_n = 1'b1;
                        if (r_err != 8'hFF) begin
                            w_err_n = 8'(r_err + 8'd1);
                        end
                        if (r_retry >= RTW'(MAX_RETRY)) begin
                            w_retry_n     = '0;
                            w_init_done_n = 1'b0;
                            w_link_err_n  = 1'b1;
                            w_state_n     = S_INIT1;
                        end else begin
                            w_retry_n = RTW'(r_retry + RTW'(1));
                        end
                    end
                end
            end
            S_POLL_WAIT: begin
                if ((r_poll_cnt >= PCW'(POLL_CYCLES - 1)) && en) begin
                    w_state_n    = S_CONV;
                    w_req_n      = 1'b1;
                    w_poll_cnt_n = '0;
                end
            end
            S_CONV_WAIT: begin
                if (r_wait_cnt >= CWW'(CONV_WAIT - 1)) begin
                    w_state_n  = S_READ;
                    w_req_n    = 1'b1;
                    w_nbytes_n = '0;
                end else begin
                    w_wait_cnt_n = CWW'(r_wait_cnt + CWW'(1));
                end
            end
            S_PUBLISH: begin
                w_state_n = S_POLL_WAIT;
            end
            default: begin
                w_state_n = S_INIT1;
            end
        endcase

        // Transaction attributes follow the state being entered so they are stable with txn_req.
        case (w_state_n)
            S_INIT1: begin
                w_rw_n  = 1'b0;
                w_len_n = 3'd2;
`ifdef NUNCHUCK_LEGACY_INIT_EN
                w_wd0_n = 8'h40;
                w_wd1_n = 8'h00;
`else
                w_wd0_n = 8'hF0;
                w_wd1_n = 8'h55;
`endif
            end
            S_INIT2: begin
                w_rw_n  = 1'b0;
                w_len_n = 3'd2;
                w_wd0_n = 8'hFB;
                w_wd1_n = 8'h00;
            end
            S_CONV: begin
                w_rw_n  = 1'b0;
                w_len_n = 3'd1;
                w_wd0_n = 8'h00;
                w_wd1_n = 8'h00;
            end
            S_READ: begin
                w_rw_n  = 1'b1;
                w_len_n = 3'd6;
                w_wd0_n = 8'h00;
                w_wd1_n = 8'h00;
            end
            default: ;
        endcase
    end

    assign txn_req    = r_req;
    assign txn_rw     = r_rw;
    assign txn_addr   = DEV_ADDR;
    assign txn_len    = r_len;
    assign txn_wdata0 = r_wd0;
    assign txn_wdata1 = r_wd1;
    assign data_out   = r_data;
    assign data_valid = r_dv;
    assign init_done  = r_init_done;
    assign link_err   = r_link_err;
    assign err_count  = r_err;

endmodule

// File: tb/tb_nunchuck_poller.sv
// Testbench for nunchuck_poller: a randomized I2C master model serves
// transactions, a scoreboard predicts published reports and error counts.
// Honours NUNCHUCK_LEGACY_INIT_EN in the same way as the design.
module tb_nunchuck_poller;

    localparam int P   = 300;
    localparam int CW  = 20;
    localparam int MR  = 3;
`ifdef NUNCHUCK_LEGACY_INIT_EN
    localparam int INIT_N = 1;
`else
    localparam int INIT_N = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       txn_req, txn_rw;
    logic [6:0] txn_addr;
    logic [2:0] txn_len;
    logic [7:0] txn_wdata0, txn_wdata1;
    logic       txn_done, txn_nack, rd_valid;
    logic [7:0] rd_data;
    logic [7:0] data_out [0:5];
    logic       data_valid, init_done, link_err;
    logic [7:0] err_count;

    nunchuck_poller #(.DEV_ADDR(7'h52), .POLL_CYCLES(P), .CONV_WAIT(CW), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .en(en),
        .txn_req(txn_req), .txn_rw(txn_rw), .txn_addr(txn_addr), .txn_len(txn_len),
        .txn_wdata0(txn_wdata0), .txn_wdata1(txn_wdata1),
        .txn_done(txn_done), .txn_nack(txn_nack), .rd_valid(rd_valid), .rd_data(rd_data),
        .data_out(data_out), .data_valid(data_valid), .init_done(init_done),
        .link_err(link_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [2:0] len;
        logic [6:0] addr;
        logic [7:0] w0;
        logic [7:0] w1;
        int         start;
        int         done;
    } txn_t;

    txn_t        log_q[$];
    logic [47:0] exp_q[$];
    int          vectors = 0, miscompares = 0, cyc = 0, dv_count = 0;
    int          nack_budget = 0, short_budget = 0, exp_err = 0;
    bit          use_fixed = 0, expect_reissue = 0;
    logic [7:0]  fixed_bytes [0:5];
    logic [7:0]  last_pub [0:5];

    localparam logic [26:0] EXP_INIT1 =
`ifdef NUNCHUCK_LEGACY_INIT_EN
        {1'b0, 3'd2, 7'h52, 8'h40, 8'h00};
`else
        {1'b0, 3'd2, 7'h52, 8'hF0, 8'h55};
`endif
    localparam logic [26:0] EXP_INIT2 = {1'b0, 3'd2, 7'h52, 8'hFB, 8'h00};
    localparam logic [26:0] EXP_CONV  = {1'b0, 3'd1, 7'h52, 8'h00, 8'h00};
    localparam logic [26:0] EXP_READ  = {1'b1, 3'd6, 7'h52, 8'h00, 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [26:0] fields(input txn_t t);
        return {t.rw, t.len, t.addr, t.w0, t.w1};
    endfunction

    function automatic logic [7:0] model_store(input logic [7:0] b);
`ifdef NUNCHUCK_LEGACY_INIT_EN
        logic [8:0] s;
        s = {1'b0, b ^ 8'h17} + 9'h017;
        return s[7:0];
`else
        return b;
`endif
    endfunction

    // Master model: serve one transaction with random latency and planned faults.
    task automatic serve();
        txn_t        t;
        int          idx, lat, nb;
        bit          nack, fail;
        logic [47:0] rep;
        logic [7:0]  b;
        t.rw = txn_rw; t.len = txn_len; t.addr = txn_addr;
        t.w0 = txn_wdata0; t.w1 = txn_wdata1; t.start = cyc; t.done = -1;
        idx = log_q.size();
        log_q.push_back(t);
        rep = '0; nb = 0;
        lat = $urandom_range(1, 4);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (reset) return;
            vectors++;
            if ({txn_req, fields(t)} !== {txn_req & 1'b1, txn_rw, txn_len, txn_addr, txn_wdata0, txn_wdata1} || txn_req !== 1'b1) begin
                miscompares++;
                $display("FAIL handshake_hold: got req=%b attrs=%h, required req=1 attrs=%h",
                         txn_req, {txn_rw, txn_len, txn_addr, txn_wdata0, txn_wdata1}, fields(t));
            end
        end
        if (t.rw) begin
            nb = (short_budget > 0) ? 5 : 6;
            if (short_budget > 0) short_budget--;
            for (int i = 0; i < nb; i++) begin
                b = use_fixed ? fixed_bytes[i] : 8'($urandom);
                rep[8*i +: 8] = b;
                rd_valid = 1'b1; rd_data = b;
                @(negedge clk);
                rd_valid = 1'b0;
                if (reset) return;
            end
            if (nb == 6 && $urandom_range(0, 3) == 0) begin
                rd_valid = 1'b1; rd_data = 8'($urandom);
                @(negedge clk);
                rd_valid = 1'b0;
                if (reset) return;
            end
        end
        nack = (nack_budget > 0);
        if (nack) nack_budget--;
        fail = nack || (t.rw && nb != 6);
        if (fail) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        else if (t.rw) exp_q.push_back(rep);
        log_q[idx].done = cyc;
        txn_done = 1'b1; txn_nack = nack;
        @(negedge clk);
        txn_done = 1'b0; txn_nack = 1'b0;
        if (reset) return;
        vectors++;
        if (txn_req !== 1'b0) begin
            miscompares++;
            $display("FAIL req_drop: got txn_req=%b after done, required 0", txn_req);
        end
        expect_reissue = fail;
    endtask

    initial begin : master
        txn_done = 1'b0; txn_nack = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                expect_reissue = 0; rd_valid = 1'b0; txn_done = 1'b0; txn_nack = 1'b0;
            end else begin
                if (expect_reissue) begin
                    vectors++;
                    if (txn_req !== 1'b1) begin
                        miscompares++;
                        $display("FAIL reissue_gap: got txn_req=%b two cycles after failure, required 1", txn_req);
                    end
                    expect_reissue = 0;
                end
                if (txn_req) serve();
            end
        end
    end

    // Scoreboard on data_out / data_valid.
    initial begin : monitor
        logic        prev_dv, bad;
        logic [47:0] rep, got, want;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) got[8*i +: 8] = data_out[i];
            if (reset) begin
                for (int i = 0; i < 6; i++) last_pub[i] = 8'h00;
                prev_dv = 1'b0;
            end else if (data_valid) begin
                dv_count++;
                vectors++;
                if (prev_dv || exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL data_valid_pulse: got unexpected pulse (pending=%0d prev=%b), required none", exp_q.size(), prev_dv);
                end else begin
                    rep = exp_q.pop_front();
                    for (int i = 0; i < 6; i++) want[8*i +: 8] = model_store(rep[8*i +: 8]);
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL data_out: got %h, required %h (byte0 in LSBs)", got, want);
                    end
                end
                for (int i = 0; i < 6; i++) last_pub[i] = data_out[i];
                prev_dv = 1'b1;
            end else begin
                prev_dv = 1'b0;
                vectors++;
                bad = 1'b0;
                for (int i = 0; i < 6; i++) if (data_out[i] !== last_pub[i]) bad = 1'b1;
                if (bad) begin
                    miscompares++;
                    $display("FAIL data_out_hold: got %h without data_valid, required unchanged", got);
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic timeout_fail(input string what);
        vectors++;
        miscompares++;
        $display("FAIL timeout_%s: got no event within budget, required event", what);
    endtask

    task automatic wait_dv(input int n);
        int k = 0;
        while (dv_count < n && k < 3000) begin @(negedge clk); k++; end
        if (dv_count < n) timeout_fail("data_valid");
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (log_q.size() < n && k < 3000) begin @(negedge clk); k++; end
        if (log_q.size() < n) timeout_fail("txn");
    endtask

    task automatic wait_read_start(input int n);
        int  k = 0;
        bit  seen = 0;
        while (!seen && k < 3000) begin
            @(negedge clk); k++;
            for (int i = n; i < log_q.size(); i++) if (log_q[i].rw) seen = 1;
        end
        if (!seen) timeout_fail("read_start");
    endtask

    task automatic wait_flag(input string what, input bit want_init, input bit want_link);
        int k = 0;
        while (!((want_init && init_done === 1'b1) || (want_link && link_err === 1'b1)) && k < 3000) begin
            @(negedge clk); k++;
        end
        if (k >= 3000) timeout_fail(what);
    endtask

    task automatic test_reset();
        logic [47:0] got;
        reset = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) got[8*i +: 8] = data_out[i];
        vectors++;
        if ({txn_req, data_valid, init_done, link_err, err_count, got} !== {4'b0000, 8'h00, 48'h0}) begin
            miscompares++;
            $display("FAIL reset_state: got req=%b dv=%b init=%b link=%b err=%h data=%h, required all zero",
                     txn_req, data_valid, init_done, link_err, err_count, got);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (txn_req !== 1'b1) begin
            miscompares++;
            $display("FAIL init1_first_edge: got txn_req=%b, required 1", txn_req);
        end
    endtask

    task automatic test_init();
        wait_log(INIT_N + 2);
        if (log_q.size() < INIT_N + 2) return;
        vectors++;
        if (fields(log_q[0]) !== EXP_INIT1) begin
            miscompares++;
            $display("FAIL init1_txn: got %h, required %h", fields(log_q[0]), EXP_INIT1);
        end
`ifndef NUNCHUCK_LEGACY_INIT_EN
        vectors++;
        if (fields(log_q[1]) !== EXP_INIT2) begin
            miscompares++;
            $display("FAIL init2_txn: got %h, required %h", fields(log_q[1]), EXP_INIT2);
        end
`endif
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL init_done: got %b, required 1", init_done);
        end
        vectors++;
        if (fields(log_q[INIT_N]) !== EXP_CONV || log_q[INIT_N].start - log_q[INIT_N-1].done != P + 1) begin
            miscompares++;
            $display("FAIL first_conv: got %h after %0d cycles, required %h after %0d",
                     fields(log_q[INIT_N]), log_q[INIT_N].start - log_q[INIT_N-1].done, EXP_CONV, P + 1);
        end
        vectors++;
        if (fields(log_q[INIT_N+1]) !== EXP_READ || log_q[INIT_N+1].start - log_q[INIT_N].done != CW + 1) begin
            miscompares++;
            $display("FAIL conv_wait_read: got %h after %0d cycles, required %h after %0d",
                     fields(log_q[INIT_N+1]), log_q[INIT_N+1].start - log_q[INIT_N].done, EXP_READ, CW + 1);
        end
    endtask

    task automatic test_fixed_read();
        logic [47:0] got;
        int          c0;
        wait_dv(dv_count + 1);
        fixed_bytes = '{8'h80, 8'h7F, 8'h12, 8'h34, 8'h56, 8'hF3};
        use_fixed = 1;
        c0 = dv_count;
        wait_dv(c0 + 1);
        for (int i = 0; i < 6; i++) got[8*i +: 8] = data_out[i];
`ifndef NUNCHUCK_LEGACY_INIT_EN
        vectors++;
        if (got !== 48'hF3_56_34_12_7F_80) begin
            miscompares++;
            $display("FAIL fixed_report: got %h, required f3563412 7f80", got);
        end
`endif
        repeat (5) @(negedge clk);
        vectors++;
        if (dv_count !== c0 + 1) begin
            miscompares++;
            $display("FAIL single_pulse: got %0d pulses, required 1", dv_count - c0);
        end
        fixed_bytes = '{8'h00, 8'hFF, 8'h17, 8'hE8, 8'h01, 8'hAA};
        wait_dv(dv_count + 1);
        vectors++;
`ifdef NUNCHUCK_LEGACY_INIT_EN
        if (data_out[0] !== 8'h2E) begin
            miscompares++;
            $display("FAIL legacy_byte0: got %h, required 2e", data_out[0]);
        end
`else
        if (data_out[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL raw_byte0: got %h, required 00", data_out[0]);
        end
`endif
        use_fixed = 0;
    endtask

    task automatic test_random_polls();
        int n, s[$];
        n = log_q.size();
        repeat (4) wait_dv(dv_count + 1);
        for (int i = n; i < log_q.size(); i++)
            if (fields(log_q[i]) === EXP_CONV) s.push_back(log_q[i].start);
        vectors++;
        if (s.size() < 4) begin
            miscompares++;
            $display("FAIL poll_count: got %0d conversions, required 4", s.size());
        end
        for (int k = 1; k < s.size(); k++) begin
            vectors++;
            if (s[k] - s[k-1] != P) begin
                miscompares++;
                $display("FAIL poll_period: got %0d cycles, required %0d", s[k] - s[k-1], P);
            end
        end
    endtask

    task automatic test_short_read();
        int n, c0, reads;
        wait_dv(dv_count + 1);
        short_budget = 1;
        n = log_q.size();
        c0 = dv_count;
        wait_dv(c0 + 1);
        reads = 0;
        for (int i = n; i < log_q.size(); i++) if (log_q[i].rw) reads++;
        vectors++;
        if (reads != 2 || dv_count != c0 + 1) begin
            miscompares++;
            $display("FAIL short_read_retry: got %0d reads %0d pulses, required 2 reads 1 pulse", reads, dv_count - c0);
        end
        vectors++;
        if (err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL err_count_short: got %0d, required %0d", err_count, exp_err);
        end
    endtask

    task automatic test_retry_overflow();
        int          n;
        logic [47:0] kept, got;
        wait_dv(dv_count + 1);
        for (int i = 0; i < 6; i++) kept[8*i +: 8] = last_pub[i];
        nack_budget = MR + 1;
        n = log_q.size();
        wait_flag("link_err", 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) got[8*i +: 8] = data_out[i];
        vectors++;
        if ({link_err, init_done} !== 2'b10 || got !== kept) begin
            miscompares++;
            $display("FAIL reinit_flags: got link=%b init=%b data=%h, required link=1 init=0 data=%h",
                     link_err, init_done, got, kept);
        end
        wait_log(n + MR + 2);
        if (log_q.size() < n + MR + 2) return;
        for (int i = 0; i <= MR; i++) begin
            vectors++;
            if (fields(log_q[n+i]) !== EXP_CONV) begin
                miscompares++;
                $display("FAIL conv_retry%0d: got %h, required %h", i, fields(log_q[n+i]), EXP_CONV);
            end
        end
        vectors++;
        if (fields(log_q[n+MR+1]) !== EXP_INIT1) begin
            miscompares++;
            $display("FAIL reinit_txn: got %h, required %h", fields(log_q[n+MR+1]), EXP_INIT1);
        end
        vectors++;
        if (err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL err_count_nack: got %0d, required %0d", err_count, exp_err);
        end
        wait_flag("reinit_done", 1'b1, 1'b0);
    endtask

    task automatic test_en_low();
        int n2, c0, ce;
        wait_read_start(log_q.size());
        en = 1'b0;
        c0 = dv_count;
        wait_dv(c0 + 1);
        n2 = log_q.size();
        repeat (2 * P) @(negedge clk);
        vectors++;
        if (log_q.size() !== n2 || txn_req !== 1'b0) begin
            miscompares++;
            $display("FAIL en_park: got %0d new txns req=%b, required 0 and 0", log_q.size() - n2, txn_req);
        end
        en = 1'b1;
        ce = cyc;
        wait_log(n2 + 1);
        if (log_q.size() < n2 + 1) return;
        vectors++;
        if (fields(log_q[n2]) !== EXP_CONV || log_q[n2].start - ce != 1) begin
            miscompares++;
            $display("FAIL en_resume: got %h after %0d cycles, required %h after 1",
                     fields(log_q[n2]), log_q[n2].start - ce, EXP_CONV);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] got;
        int          n;
        wait_read_start(log_q.size());
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) got[8*i +: 8] = data_out[i];
        vectors++;
        if ({txn_req, data_valid, init_done, link_err, err_count, got} !== {4'b0000, 8'h00, 48'h0}) begin
            miscompares++;
            $display("FAIL reset_mid: got req=%b dv=%b init=%b link=%b err=%h data=%h, required all zero",
                     txn_req, data_valid, init_done, link_err, err_count, got);
        end
        exp_q.delete();
        exp_err = 0; nack_budget = 0; short_budget = 0;
        repeat (3) @(negedge clk);
        n = log_q.size();
        reset = 1'b0;
        wait_log(n + 1);
        if (log_q.size() < n + 1) return;
        vectors++;
        if (fields(log_q[n]) !== EXP_INIT1) begin
            miscompares++;
            $display("FAIL reset_reinit: got %h, required %h", fields(log_q[n]), EXP_INIT1);
        end
        wait_flag("init_after_reset", 1'b1, 1'b0);
        wait_dv(dv_count + 1);
    endtask

    initial begin
        test_reset();
        test_init();
        test_fixed_read();
        test_random_polls();
        test_short_read();
        test_retry_overflow();
        test_en_low();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nunchuck_poller.md
NUNCHUCK_POLLER -- requirements
Module: nunchuck_poller

Interface
REQ-001 Parameters SHALL be, one per line:
- DEV_ADDR, 7'h52: nunchuck I2C address.
- POLL_CYCLES, 50000: clk cycles from poll start to next poll start.
- CONV_WAIT, 10000: clk cycles between the conversion write and the read.
- MAX_RETRY, 3: consecutive failed transactions tolerated before re-init.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  polling enable.
- txn_req  out  1  transaction request to I2C master.
- txn_rw  out  1  0 = write, 1 = read.
- txn_addr  out  7  device address; always DEV_ADDR.
- txn_len  out  3  write: 1 or 2 bytes; read: 6.
- txn_wdata0  out  8  first write byte.
- txn_wdata1  out  8  second write byte.
- txn_done  in  1  one-cycle transaction-complete strobe.
- txn_nack  in  1  valid with txn_done; 1 = failed.
- rd_valid  in  1  one-cycle strobe per received byte.
- rd_data  in  8  received byte.
- data_out  out  [7:0] x [5:0]  last good 6-byte report, unpacked array, index 0 = first byte.
- data_valid  out  1  one-cycle pulse on data_out update.
- init_done  out  1  device initialised.
- link_err  out  1  sticky: a re-init was forced.
- err_count  out  8  saturating failed-transaction count.

Function
REQ-003 FSM states SHALL be INIT1, INIT2, POLL_WAIT, CONV, CONV_WAIT, READ, PUBLISH.
REQ-004 INIT1 SHALL issue a write of 0xF0,0x55 (len 2); on success go to INIT2.
REQ-005 INIT2 SHALL issue a write of 0xFB,0x00 (len 2); on success set init_done and go to POLL_WAIT.
REQ-006 POLL_WAIT SHALL count to POLL_CYCLES from entry; at expiry with en=1 go to CONV; with en=0 hold until en=1, then go to CONV on the next cycle.
REQ-007 CONV SHALL issue a write of 0x00 (len 1); on success go to CONV_WAIT, which counts CONV_WAIT cycles and then goes to READ.
REQ-008 READ SHALL issue a read (len 6) and capture rd_data on each rd_valid into shadow slot 0..5 in order; rd_valid beyond six bytes SHALL be ignored.
REQ-009 A read SHALL succeed only if txn_done arrives with txn_nack=0 and exactly 6 bytes captured; on success go to PUBLISH.
REQ-010 PUBLISH SHALL copy all six shadow bytes into data_out in one cycle, pulse data_valid for that same cycle, and return to POLL_WAIT. data_out SHALL never be partially updated.
REQ-011 Handshake: txn_req SHALL rise on state entry and stay high, with txn_rw/len/wdata stable, until the cycle txn_done is sampled; it SHALL be low the following cycle. txn_done while txn_req=0 SHALL be ignored.
REQ-012 Each failed transaction SHALL increment err_count (saturating at 255) and the retry counter, then re-issue the same transaction after one idle cycle.
REQ-013 Any success SHALL clear the retry counter.
REQ-014 A failure that takes the retry counter above MAX_RETRY SHALL clear init_done, set link_err, clear the retry counter and go to INIT1. data_out SHALL be retained.
REQ-015 The POLL_CYCLES period SHALL be measured from CONV entry to the next CONV entry, independent of master latency, unless the transactions overrun it; on overrun the next poll SHALL start immediately.
REQ-016 en falling mid-transaction SHALL NOT abort it; the FSM SHALL park in POLL_WAIT afterwards.

Reset
REQ-017 Reset SHALL asynchronously force state INIT1, txn_req=0, all data_out bytes=0x00, data_valid=0, init_done=0, link_err=0, err_count=0, and clear the counters and shadow buffer. INIT1 SHALL issue its request on the first clk edge after reset deasserts.
REQ-018 Reset asserted mid-transaction SHALL drop txn_req immediately; a late txn_done or rd_valid SHALL be ignored.

Configuration
REQ-019 Macro NUNCHUCK_LEGACY_INIT_EN defined: the init sequence SHALL be a single write of 0x40,0x00 (INIT2 skipped), and each captured byte SHALL be stored as ((rd_data ^ 0x17) + 0x17) mod 256.
REQ-020 Macro undefined: the init sequence SHALL be REQ-004/REQ-005 and bytes SHALL be stored raw.

Verification
REQ-021 Reset release with a master model acking all transactions: writes F0/55, FB/00, then 00; after CONV_WAIT a len-6 read; init_done=1.
REQ-022 Read returns 80,7F,12,34,56,F3: data_out = {80,7F,12,34,56,F3}, one data_valid pulse; next CONV exactly POLL_CYCLES after the previous CONV entry.
REQ-023 Read completes with 5 bytes and nack=0: no data_valid, data_out unchanged, err_count +1, read reissued.
REQ-024 MAX_RETRY+1 consecutive nacks on CONV: link_err=1, init_done=0, INIT1 reissued, data_out kept.
REQ-025 en=0 during READ: read completes and publishes, then no further txn_req until en=1.
REQ-026 With NUNCHUCK_LEGACY_INIT_EN, read byte 0x00: only 40/00 init issued; stored byte = 0x2E.
